// File: rtl/rev_rr_scheduler_pkg.sv
// Shared types, widths and the bit-mirror helper for the round-robin
// bit-reversal scheduler.
package rev_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OPCNT_W    = 16;
    localparam int MAX_DATA_W = 64;

    // Mirrors the low data_w bits of d; bits at and above data_w come back zero.
    function automatic logic [MAX_DATA_W-1:0] rev_bits(input logic [MAX_DATA_W-1:0] d,
                                                       input int data_w);
        logic [MAX_DATA_W-1:0] r;
        logic [5:0] dst;
        logic [5:0] src;
        r = '0;
        for (int k = 0; k < MAX_DATA_W; k++) begin
            if (k < data_w) begin
                dst    = 6'(k);
                src    = 6'(data_w - 1 - k);
                r[dst] = d[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rev_rr_scheduler_if.sv
// Requester-side and result-side handshake bundle for rev_rr_scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface rev_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/rev_rr_scheduler_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
module rev_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_valid
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/rev_rr_scheduler.sv
// Round-robin front end sharing one LAT-stage bit-reversal pipe; one word in
// flight at a time, result returned with the id of its requester.
//
//   state | meaning
//   IDLE  | arbitrating; req_ready carries the one-hot grant
//   PROC  | word travelling down the reversal pipe, cnt counting down
//   DONE  | out_valid high, result held until out_ready
module rev_rr_scheduler
    import rev_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int LAT     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    rev_rr_scheduler_if.slave  bus,
    output logic               busy,
    output logic [OPCNT_W-1:0] op_count
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cnt_tc;
    logic [OPCNT_W-1:0] op_cnt_q;
    logic [DATA_W-1:0]  pipe_data [LAT];
    logic [ID_W-1:0]    pipe_id   [LAT];

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_valid;
    logic               accept;
    logic [DATA_W-1:0]  sel_word;
    logic [DATA_W-1:0]  rev_word;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    rev_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .en        (state == IDLE && rst_n),
        .grant     (grant),
        .idx       (grant_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_word = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rev_word = DATA_W'(rev_bits(MAX_DATA_W'(sel_word), DATA_W));
    assign accept   = (state == IDLE) && any_valid;
    assign cnt_nxt  = cnt - 1'b1;
    assign cnt_tc   = (cnt_nxt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = (LAT == 1) ? DONE : PROC;
            PROC:    if (cnt_tc) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            op_cnt_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_data[i] <= '0;
                pipe_id[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                pipe_data[0] <= rev_word;
                pipe_id[0]   <= grant_idx;
                rr_ptr       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                cnt          <= CNT_W'(LAT - 1);
            end
            if (state == PROC) begin
                cnt <= cnt_nxt;
                for (int i = 1; i < LAT; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_id[i]   <= pipe_id[i-1];
                end
            end
            if (state == DONE && bus.out_ready) begin
                op_cnt_q <= op_cnt_q + 1'b1;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = pipe_data[LAT-1];
    assign bus.out_id    = pipe_id[LAT-1];
    assign busy          = (state != IDLE);
    assign op_count      = op_cnt_q;

endmodule

// File: tb/tb_rev_rr_scheduler.sv
// Directed bench for rev_rr_scheduler: expected results are queued when a word
// is offered and a negedge monitor checks every output handshake against them.
module tb_rev_rr_scheduler;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    rev_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus ();
    rev_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus1 ();
    logic        busy, busy1;
    logic [15:0] op_count, op_count1;

    rev_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .LAT(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    rev_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .LAT(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .busy     (busy1),
        .op_count (op_count1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got data %h id %0d, expected no result",
                         bus.out_data, bus.out_id);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.out_data !== mon_e.data || bus.out_id !== mon_e.id) begin
                    n_fail++;
                    $display("FAIL result: got data %h id %0d, expected data %h id %0d",
                             bus.out_data, bus.out_id, mon_e.data, mon_e.id);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] exp_gnt, input logic [3:0] clr, output int gcyc);
        logic [3:0] g;
        bit found;
        found = 1'b0;
        g     = '0;
        gcyc  = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.req_ready != 4'b0) begin
                found = 1'b1;
                g     = bus.req_ready;
                gcyc  = cyc;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: got no grant, expected %b", exp_gnt);
        end else begin
            check("grant", 32'(g), 32'(exp_gnt));
        end
        if (clr != 4'b0) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~clr;
        end
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!bus.out_valid && i < 20);
        check("out_valid_wait", 32'(bus.out_valid), 32'h1);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, g2, g3;
        bus.req_valid  = 4'b1111;
        bus.req_data   = '0;
        bus.out_ready  = 1'b0;
        bus1.req_valid = 4'b0;
        bus1.req_data  = '0;
        bus1.out_ready = 1'b0;

        // reset state, with requests pending so req_ready gating is visible
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy",      32'(busy),          32'h0);
        check("rst_op_count",  32'(op_count),      32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_id",    32'(bus.out_id),    32'h0);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        rst_n = 1'b1;

        // single word from requester 1
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.req_data  = {8'h00, 8'h00, 8'h01, 8'h00};
        bus.req_valid = 4'b0010;
        exp_q.push_back('{data: 8'h80, id: 2'd1});
        @(negedge clk);
        check("t1_grant",      32'(bus.req_ready), 32'h2);
        check("t1_busy_T",     32'(busy),          32'h0);
        @(posedge clk); #1;
        bus.req_valid = 4'b0;
        @(negedge clk);
        check("t1_busy_T1",    32'(busy),          32'h1);
        check("t1_valid_T1",   32'(bus.out_valid), 32'h0);
        @(negedge clk);
        check("t1_valid_T2",   32'(bus.out_valid), 32'h1);
        check("t1_busy_T2",    32'(busy),          32'h1);
        @(negedge clk);
        check("t1_valid_T3",   32'(bus.out_valid), 32'h0);
        check("t1_busy_T3",    32'(busy),          32'h0);
        check("t1_op_count",   32'(op_count),      32'h1);

        // all four requesters after reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_data  = {8'h3C, 8'hA5, 8'h0F, 8'hF0};
        bus.req_valid = 4'b1111;
        exp_q.push_back('{data: 8'h0F, id: 2'd0});
        exp_q.push_back('{data: 8'hF0, id: 2'd1});
        exp_q.push_back('{data: 8'hA5, id: 2'd2});
        exp_q.push_back('{data: 8'h3C, id: 2'd3});
        for (int i = 0; i < 4; i++) begin
            wait_grant(4'(1 << i), 4'(1 << i), g0);
        end
        wait_drain();
        @(negedge clk);
        check("t2_op_count", 32'(op_count), 32'h4);

        // output stall, with requesters 0 and 2 waiting behind it
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.req_data  = {8'hC1, 8'h00, 8'h00, 8'h00};
        bus.req_valid = 4'b1000;
        exp_q.push_back('{data: 8'h83, id: 2'd3});
        wait_grant(4'b1000, 4'b1000, g0);
        bus.req_data  = {8'h00, 8'h55, 8'h00, 8'h12};
        bus.req_valid = 4'b0101;
        exp_q.push_back('{data: 8'h48, id: 2'd0});
        exp_q.push_back('{data: 8'hAA, id: 2'd2});
        exp_q.push_back('{data: 8'h48, id: 2'd0});
        exp_q.push_back('{data: 8'hAA, id: 2'd2});
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold_valid", 32'(bus.out_valid), 32'h1);
            check("t3_hold_data",  32'(bus.out_data),  32'h83);
            check("t3_hold_id",    32'(bus.out_id),    32'h3);
            check("t3_hold_ready", 32'(bus.req_ready), 32'h0);
            check("t3_hold_count", 32'(op_count),      32'h4);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_hs_count", 32'(op_count), 32'h4);
        @(negedge clk);
        check("t3_idle_busy",  32'(busy),          32'h0);
        check("t3_idle_valid", 32'(bus.out_valid), 32'h0);

        // continuous requesters 0 and 2 alternate every LAT+1 cycles
        check("t4_grant0", 32'(bus.req_ready), 32'h1);
        g0 = cyc;
        wait_grant(4'b0100, 4'b0000, g1);
        wait_grant(4'b0001, 4'b0000, g2);
        wait_grant(4'b0100, 4'b1111, g3);
        check("t4_interval1", 32'(g1 - g0), 32'd3);
        check("t4_interval2", 32'(g2 - g1), 32'd3);
        check("t4_interval3", 32'(g3 - g2), 32'd3);
        wait_drain();
        @(negedge clk);
        check("t4_op_count", 32'(op_count), 32'h9);

        // reset in the middle of PROC
        @(posedge clk); #1;
        bus.req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        bus.req_valid = 4'b0010;
        exp_q.push_back('{data: 8'h5A, id: 2'd1});
        wait_grant(4'b0010, 4'b0010, g0);
        bus.req_data  = {8'hFF, 8'h00, 8'h00, 8'h01};
        bus.req_valid = 4'b1001;
        #2;
        check("t5_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t5_rst_busy",  32'(busy),          32'h0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'h0);
        check("t5_rst_count", 32'(op_count),      32'h0);
        check("t5_rst_id",    32'(bus.out_id),    32'h0);
        exp_q.delete();
        exp_q.push_back('{data: 8'h80, id: 2'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_grant(4'b0001, 4'b1111, g0);
        wait_drain();
        @(negedge clk);
        check("t5_op_count", 32'(op_count), 32'h1);

        // op_count wrap, palindromic word
        @(posedge clk); #1;
        force u_dut.op_cnt_q = 16'hFFFF;
        #1;
        release u_dut.op_cnt_q;
        @(negedge clk);
        check("t6_preload", 32'(op_count), 32'hFFFF);
        @(posedge clk); #1;
        bus.req_data  = {8'h00, 8'h00, 8'h81, 8'h00};
        bus.req_valid = 4'b0010;
        exp_q.push_back('{data: 8'h81, id: 2'd1});
        wait_grant(4'b0010, 4'b0010, g0);
        wait_drain();
        @(negedge clk);
        check("t6_wrap", 32'(op_count), 32'h0);

        // LAT=1 build: result one cycle after acceptance
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        bus1.req_data  = {8'h00, 8'h03, 8'h00, 8'h00};
        bus1.req_valid = 4'b0100;
        @(negedge clk);
        check("l1_grant", 32'(bus1.req_ready), 32'h4);
        check("l1_valid_T", 32'(bus1.out_valid), 32'h0);
        @(posedge clk); #1;
        bus1.req_valid = 4'b0;
        @(negedge clk);
        check("l1_valid_T1", 32'(bus1.out_valid), 32'h1);
        check("l1_data",     32'(bus1.out_data),  32'hC0);
        check("l1_id",       32'(bus1.out_id),    32'h2);
        check("l1_busy",     32'(busy1),          32'h1);
        @(negedge clk);
        check("l1_valid_T2", 32'(bus1.out_valid), 32'h0);
        check("l1_idle",     32'(busy1),          32'h0);
        check("l1_op_count", 32'(op_count1),      32'h1);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
